// File: rtl/bus_host_initiator.sv
// Single-outstanding bus host: turns one valid/ready command into one device-bus
// transaction and returns one response carrying read data or a timeout error.
module bus_host_initiator #(
    parameter int TimeoutCycles = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [3:0]  cmd_be_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            timeout;

    // The counter holds the number of completed cycles in the current state,
    // so the last permitted cycle is the one where it reads TimeoutCycles-1.
    assign timeout = (cnt_q == CntLast);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        host_req_o  = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = REQ;
            end
            REQ: begin
                host_req_o = 1'b1;
                if (host_gnt_i)   state_d = WAIT;
                else if (timeout) state_d = RESP;
            end
            WAIT: begin
                if (host_rvalid_i || timeout) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            host_addr_o  <= '0;
            host_we_o    <= 1'b0;
            host_be_o    <= '0;
            host_wdata_o <= '0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q)  cnt_q <= '0;
            else if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        host_addr_o  <= {cmd_addr_i[31:2], 2'b00};
                        host_we_o    <= cmd_we_i;
                        host_be_o    <= cmd_we_i ? cmd_be_i : 4'hF;
                        host_wdata_o <= cmd_we_i ? cmd_wdata_i : 32'h0;
                        rsp_rdata_o  <= '0;
                        rsp_err_o    <= 1'b0;
                    end
                end
                REQ: begin
                    if (!host_gnt_i && timeout) rsp_err_o <= 1'b1;
                end
                WAIT: begin
                    // A response arriving in the timeout cycle still counts.
                    if (host_rvalid_i) begin
                        rsp_rdata_o <= host_we_o ? 32'h0 : host_rdata_i;
                        rsp_err_o   <= 1'b0;
                    end else if (timeout) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_host_initiator.sv
// Self-checking bench for bus_host_initiator: directed scenarios plus randomized
// transactions checked against a phase-level model of the host protocol.
module tb_bus_host_initiator;

    localparam int T = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0;
    logic [3:0]  cmd_be_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic        host_req_o;
    logic        host_gnt_i = 1'b0;
    logic [31:0] host_addr_o;
    logic        host_we_o;
    logic [3:0]  host_be_o;
    logic [31:0] host_wdata_o;
    logic        host_rvalid_i = 1'b0;
    logic [31:0] host_rdata_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bus_host_initiator #(.TimeoutCycles(T)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_we_i      (cmd_we_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_be_i      (cmd_be_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .host_req_o    (host_req_o),
        .host_gnt_i    (host_gnt_i),
        .host_addr_o   (host_addr_o),
        .host_we_o     (host_we_o),
        .host_be_o     (host_be_o),
        .host_wdata_o  (host_wdata_o),
        .host_rvalid_i (host_rvalid_i),
        .host_rdata_i  (host_rdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o)
    );

    // Runs one command end to end. The model works in protocol phases: the
    // request phase lasts until the grant (or T cycles), the wait phase until
    // rvalid (or T cycles), and the response is held for rdy_dly extra cycles.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                           input int rdy_dly, input logic [31:0] dev_rdata, output int lat);
        logic [31:0] exp_addr, exp_rdata;
        logic [3:0]  exp_be;
        logic        exp_err;
        int          req_cycles, wait_cycles;
        exp_addr    = {addr[31:2], 2'b00};
        exp_be      = we ? be : 4'hF;
        req_cycles  = (gnt_dly < T) ? gnt_dly + 1 : T;
        wait_cycles = (gnt_dly >= T) ? 0 : ((rv_dly < T) ? rv_dly + 1 : T);
        exp_err     = (gnt_dly >= T) || (rv_dly >= T);
        exp_rdata   = (exp_err || we) ? 32'h0 : dev_rdata;

        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: cmd_ready_o=%b expected 1", cmd_ready_o);
        end
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_be_i = be; cmd_wdata_i = wdata;
        @(negedge clk_i);
        cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_wdata_i = $urandom; cmd_be_i = 4'($urandom);
        lat = 1;

        for (int i = 0; i < req_cycles; i++) begin
            checks++;
            if ({host_req_o, cmd_ready_o, rsp_valid_o, host_addr_o, host_we_o, host_be_o}
                !== {3'b100, exp_addr, we, exp_be}) begin
                errors++;
                $display("FAIL req_phase[%0d]: req=%b rdy=%b rv=%b addr=%h we=%b be=%h expected 1 0 0 %h %b %h",
                         i, host_req_o, cmd_ready_o, rsp_valid_o, host_addr_o, host_we_o, host_be_o,
                         exp_addr, we, exp_be);
            end
            if (we) begin
                checks++;
                if (host_wdata_o !== wdata) begin
                    errors++;
                    $display("FAIL req_wdata[%0d]: host_wdata_o=%h expected %h", i, host_wdata_o, wdata);
                end
            end
            host_gnt_i    = (i == gnt_dly);
            host_rvalid_i = 1'($urandom_range(0, 1));
            host_rdata_i  = $urandom;
            @(negedge clk_i);
            host_gnt_i = 1'b0; host_rvalid_i = 1'b0;
            lat++;
        end

        for (int i = 0; i < wait_cycles; i++) begin
            checks++;
            if ({host_req_o, cmd_ready_o, rsp_valid_o} !== 3'b000) begin
                errors++;
                $display("FAIL wait_phase[%0d]: req=%b rdy=%b rv=%b expected 0 0 0",
                         i, host_req_o, cmd_ready_o, rsp_valid_o);
            end
            host_rvalid_i = (i == rv_dly);
            host_rdata_i  = (i == rv_dly) ? dev_rdata : $urandom;
            @(negedge clk_i);
            host_rvalid_i = 1'b0;
            lat++;
        end

        for (int i = 0; i <= rdy_dly; i++) begin
            checks++;
            if ({rsp_valid_o, cmd_ready_o, host_req_o, rsp_err_o, rsp_rdata_o}
                !== {3'b100, exp_err, exp_rdata}) begin
                errors++;
                $display("FAIL resp_phase[%0d]: rv=%b rdy=%b req=%b err=%b rdata=%h expected 1 0 0 %b %h",
                         i, rsp_valid_o, cmd_ready_o, host_req_o, rsp_err_o, rsp_rdata_o,
                         exp_err, exp_rdata);
            end
            rsp_ready_i = (i == rdy_dly);
            if (i < rdy_dly) begin
                host_rvalid_i = 1'($urandom_range(0, 1));
                host_rdata_i  = $urandom;
                cmd_valid_i   = 1'b1;
            end
            @(negedge clk_i);
            rsp_ready_i = 1'b0; host_rvalid_i = 1'b0; cmd_valid_i = 1'b0;
        end

        checks++;
        if ({cmd_ready_o, rsp_valid_o, host_req_o} !== 3'b100) begin
            errors++;
            $display("FAIL back_to_idle: rdy=%b rv=%b req=%b expected 1 0 0",
                     cmd_ready_o, rsp_valid_o, host_req_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({cmd_ready_o, host_req_o, rsp_valid_o, rsp_err_o, host_we_o, host_addr_o,
             host_be_o, host_wdata_o, rsp_rdata_o} !== {5'b10000, 32'h0, 4'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b req=%b rv=%b err=%b we=%b addr=%h be=%h wd=%h rd=%h expected 1 0 0 0 0 all-zero",
                     cmd_ready_o, host_req_o, rsp_valid_o, rsp_err_o, host_we_o, host_addr_o,
                     host_be_o, host_wdata_o, rsp_rdata_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_read_zero_wait();
        int lat;
        run_txn(1'b0, 32'h0000_0004, 4'h3, 32'hDEAD_BEEF, 0, 0, 0, 32'h0000_00A5, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL read_latency: %0d cycles expected 3", lat);
        end
    endtask

    task automatic test_write();
        int lat;
        run_txn(1'b1, 32'h0000_0000, 4'b0011, 32'h0000_1234, 0, 0, 0, 32'hFFFF_FFFF, lat);
        run_txn(1'b1, 32'hA000_0107, 4'b1000, 32'h5A5A_0F0F, 1, 2, 0, 32'h1111_2222, lat);
    endtask

    task automatic test_gnt_stall();
        int lat;
        run_txn(1'b1, 32'h0000_0010, 4'hC, 32'hCAFE_F00D, 5, 1, 0, 32'h0, lat);
        run_txn(1'b0, 32'h0000_0020, 4'h0, 32'h0, T - 1, 0, 0, 32'h7777_0001, lat);
        run_txn(1'b0, 32'h0000_0024, 4'h0, 32'h0, T + 3, 0, 0, 32'h7777_0002, lat);
    endtask

    task automatic test_wait_timeout();
        int lat;
        run_txn(1'b0, 32'h0000_0030, 4'h0, 32'h0, 0, 1000, 0, 32'h1234_5678, lat);
        checks++;
        if (lat !== 2 + T) begin
            errors++;
            $display("FAIL wait_timeout_latency: %0d cycles expected %0d", lat, 2 + T);
        end
        run_txn(1'b0, 32'h0000_0034, 4'h0, 32'h0, 0, T - 1, 0, 32'h0BAD_CAFE, lat);
    endtask

    task automatic test_rsp_backpressure();
        int lat;
        run_txn(1'b0, 32'h0000_0040, 4'h0, 32'h0, 2, 3, 4, 32'h8765_4321, lat);
        run_txn(1'b1, 32'h0000_0044, 4'h5, 32'h0000_00FF, 0, 0, 4, 32'h0, lat);
    endtask

    task automatic test_reset_in_wait();
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h0000_0050; cmd_be_i = 4'h0;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        host_gnt_i  = 1'b1;
        @(negedge clk_i);
        host_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checks++;
        if ({cmd_ready_o, host_req_o, rsp_valid_o, rsp_err_o, host_we_o, host_addr_o,
             host_be_o, host_wdata_o, rsp_rdata_o} !== {5'b10000, 32'h0, 4'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_in_wait: rdy=%b req=%b rv=%b err=%b addr=%h be=%h rd=%h expected 1 0 0 0 zeros",
                     cmd_ready_o, host_req_o, rsp_valid_o, rsp_err_o, host_addr_o, host_be_o, rsp_rdata_o);
        end
        host_rvalid_i = 1'b1; host_rdata_i = 32'hFEED_FACE;
        @(negedge clk_i);
        host_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({cmd_ready_o, rsp_valid_o, host_req_o, rsp_rdata_o} !== {3'b100, 32'h0}) begin
                errors++;
                $display("FAIL late_rvalid[%0d]: rdy=%b rv=%b req=%b rdata=%h expected 1 0 0 0",
                         i, cmd_ready_o, rsp_valid_o, host_req_o, rsp_rdata_o);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_random();
        int lat;
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                    $urandom_range(0, T + 2), $urandom_range(0, T + 2),
                    $urandom_range(0, 3), $urandom, lat);
        end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_read_zero_wait();
        test_write();
        test_gnt_stall();
        test_wait_timeout();
        test_rsp_backpressure();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
